// File: rtl/bus_fifo_reg.sv
// First-word-fall-through FIFO with valid/ready on both sides,
// occupancy count, almost-full flag and synchronous flush.
module bus_fifo_reg #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [WIDTH-1:0]             IN_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [WIDTH-1:0]             OUT_DATA,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         ALMOST_FULL
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push;
  logic             pop;

  // Ready/valid decode purely from the registered count.
  assign IN_READY    = (cnt_q != CW'(DEPTH));
  assign OUT_VALID   = (cnt_q != '0);
  assign ALMOST_FULL = (cnt_q >= CW'(AF_LEVEL));
  assign COUNT       = cnt_q;
  assign OUT_DATA    = OUT_VALID ? mem_q[rp_q] : '0;

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (FLUSH) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; stale entries are masked by the count.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) mem_q[wp_q] <= IN_DATA;
  end

endmodule

// File: tb/tb_bus_fifo_reg.sv
// Scoreboard bench for bus_fifo_reg: queue model checked every
// cycle by a negedge monitor, directed scenarios plus random traffic.
module tb_bus_fifo_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             CLK;
  logic             RSTN;
  logic             FLUSH;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic [CW-1:0]    COUNT;
  logic             ALMOST_FULL;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] mq [$];

  bus_fifo_reg #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT against the queue model, then advance model.
  always @(negedge CLK) begin
    int sz;
    logic [WIDTH-1:0] hd;
    bit do_push, do_pop;
    if (!RSTN) mq.delete();
    sz = mq.size();
    hd = (sz > 0) ? mq[0] : '0;
    check("COUNT", 64'(COUNT), 64'(sz));
    check("IN_READY", 64'(IN_READY), 64'(sz != DEPTH));
    check("OUT_VALID", 64'(OUT_VALID), 64'(sz != 0));
    check("OUT_DATA", 64'(OUT_DATA), 64'(hd));
    check("ALMOST_FULL", 64'(ALMOST_FULL), 64'(sz >= AF));
    if (RSTN) begin
      if (FLUSH) begin
        mq.delete();
      end else begin
        do_push = IN_VALID && (sz < DEPTH);
        do_pop  = OUT_READY && (sz > 0);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(IN_DATA);
      end
    end
  end

  task automatic cyc(input bit v, input logic [WIDTH-1:0] d,
                     input bit r, input bit f);
    IN_VALID  = v;
    IN_DATA   = d;
    OUT_READY = r;
    FLUSH     = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 1, 0);
  endtask

  initial begin
    RSTN = 1'b0;
    IN_VALID = 0; IN_DATA = '0; OUT_READY = 0; FLUSH = 0;
    repeat (3) @(posedge CLK);
    #3 RSTN = 1'b1;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);

    // fill, fifth push ignored, drain in order
    for (int i = 1; i <= 5; i++) cyc(1, 32'h11111111 * i, 0, 0);
    drain();

    // wrap-around with occupancy held at two
    cyc(1, 32'hC0DE0000, 0, 0);
    cyc(1, 32'hC0DE0001, 0, 0);
    for (int i = 2; i < 12; i++) cyc(1, 32'hC0DE0000 + i, 1, 0);
    drain();

    // full with simultaneous pop: only the pop is taken
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'hF00D0000 + i, 0, 0);
    cyc(1, 32'hDEADBEEF, 1, 0);
    cyc(0, '0, 0, 0);
    check("IN_READY_after_full_pop", 64'(IN_READY), 64'd1);
    drain();

    // flush beats concurrent push and pop
    for (int i = 0; i < 3; i++) cyc(1, 32'hB0000000 + i, 0, 0);
    cyc(1, 32'h12345678, 1, 1);
    check("COUNT_after_flush", 64'(COUNT), 64'd0);
    cyc(1, 32'hA5A5A5A5, 0, 0);
    check("OUT_DATA_after_flush", 64'(OUT_DATA), 64'hA5A5A5A5);
    drain();

    // asynchronous reset mid-operation
    cyc(1, 32'h0000AAAA, 0, 0);
    cyc(1, 32'h0000BBBB, 0, 0);
    IN_VALID = 0; OUT_READY = 0;
    #2 RSTN = 1'b0;
    #1;
    check("COUNT_async_rst", 64'(COUNT), 64'd0);
    check("OUT_VALID_async_rst", 64'(OUT_VALID), 64'd0);
    @(posedge CLK);
    #3 RSTN = 1'b1;
    cyc(1, 32'h0000CCCC, 0, 0);
    check("OUT_DATA_after_rst", 64'(OUT_DATA), 64'h0000CCCC);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
